// File: rtl/vga_text_ctrl_if.sv
// Text RAM read bus between vga_text_ctrl (master) and the synchronous-read text RAM (slave).
interface vga_text_ctrl_if;
  logic [11:0] ram_addr;
  logic [7:0]  ram_rdata;

  modport master (output ram_addr, input ram_rdata);
  modport slave  (input ram_addr, output ram_rdata);
endinterface

// File: rtl/vga_text_ctrl.sv
// VGA text-mode timing/sequencer: sync, cell walk, scrolled RAM addressing, block cursor.
// Optional feature macro: VGA_CURSOR_BLINK_EN (cursor blink); undefined gives a steady cursor.
module vga_text_ctrl #(
  parameter int unsigned H_VIS        = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_VIS        = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter int unsigned CELL_W       = 9,
  parameter int unsigned CELL_H       = 16,
  parameter int unsigned COLS         = 71,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                   pclk,
  input  logic                   rst,
  vga_text_ctrl_if.master        ram,
  input  logic [4:0]             top_row,
  input  logic [6:0]             cur_x,
  input  logic [4:0]             cur_y,
  input  logic                   cursor_en,
  output logic [7:0]             char,
  output logic [3:0]             h_font,
  output logic [3:0]             v_font,
  output logic                   c_valid,
  output logic                   cursor,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start
);

  localparam logic [9:0]  H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_TXT   = 10'(COLS * CELL_W);
  localparam logic [9:0]  V_TXT   = 10'(ROWS * CELL_H);
  localparam logic [9:0]  HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0]  HS_END  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [3:0]  CW_LAST = 4'(CELL_W - 1);
  localparam logic [3:0]  CH_LAST = 4'(CELL_H - 1);
  localparam logic [5:0]  ROWS_W  = 6'(ROWS);
  localparam logic [11:0] COLS_A  = 12'(COLS);

  logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [6:0] col_q, col_d;
  logic [3:0] hf_q, hf_d;
  logic [5:0] row_q, row_d;
  logic [3:0] vf_q, vf_d;

  logic [4:0] top_s_q, cur_y_s_q;
  logic [6:0] cur_x_s_q;
  logic       en_s_q;
  logic [4:0] top_ok, top_eff, cur_y_eff;
  logic [6:0] cur_x_eff;
  logic       en_eff;

  logic        h_wrap, v_wrap, fs, in_area, hs_raw, vs_raw;
  logic [5:0]  row_sum, phys_row;
  logic [11:0] addr;
  logic        cursor_hit, blink_on;

  logic [3:0] h_font_q, v_font_q;
  logic       c_valid_q, cursor_q;
  logic       hs1_q, hs2_q, vs1_q, vs2_q;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    fs      = (h_cnt_q == '0) && (v_cnt_q == '0);
    in_area = (h_cnt_q < H_TXT) && (v_cnt_q < V_TXT);
    hs_raw  = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs_raw  = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
  end

  // Cell position tracked by wrap-around sub-counters instead of divide/modulo.
  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    col_d   = col_q;
    hf_d    = hf_q + 4'd1;
    if (h_wrap) begin
      col_d = '0;
      hf_d  = '0;
    end else if (hf_q == CW_LAST) begin
      col_d = col_q + 7'd1;
      hf_d  = '0;
    end
  end

  always_comb begin
    v_cnt_d = v_cnt_q;
    row_d   = row_q;
    vf_d    = vf_q;
    if (h_wrap) begin
      if (v_wrap) begin
        v_cnt_d = '0;
        row_d   = '0;
        vf_d    = '0;
      end else begin
        v_cnt_d = v_cnt_q + 10'd1;
        if (vf_q == CH_LAST) begin
          row_d = row_q + 6'd1;
          vf_d  = '0;
        end else begin
          vf_d = vf_q + 4'd1;
        end
      end
    end
  end

  // During the frame-start cycle the live inputs are used directly, so pixel (0,0)
  // already sees the configuration that is latched for the rest of the frame.
  always_comb begin
    top_ok    = ({1'b0, top_row} >= ROWS_W) ? '0 : top_row;
    top_eff   = fs ? top_ok    : top_s_q;
    cur_x_eff = fs ? cur_x     : cur_x_s_q;
    cur_y_eff = fs ? cur_y     : cur_y_s_q;
    en_eff    = fs ? cursor_en : en_s_q;
    row_sum   = row_q + {1'b0, top_eff};
    phys_row  = (row_sum >= ROWS_W) ? row_sum - ROWS_W : row_sum;
    addr      = in_area ? (12'(phys_row) * COLS_A + {5'b0, col_q}) : '0;
    cursor_hit = in_area && en_eff && blink_on &&
                 (col_q == cur_x_eff) && (row_q == {1'b0, cur_y_eff});
  end

`ifdef VGA_CURSOR_BLINK_EN
  localparam logic [7:0] BF_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0] blink_cnt_q;
  logic       blink_on_q;

  // Counts completed frames, so the phase change lands exactly on the next frame's first pixel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (h_wrap && v_wrap) begin
      if (blink_cnt_q == BF_LAST) begin
        blink_cnt_q <= '0;
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 8'd1;
      end
    end
  end

  assign blink_on = blink_on_q;
`else
  // Steady cursor: the phase is permanently on and BLINK_FRAMES has no influence.
  localparam logic STEADY_PHASE = (BLINK_FRAMES != 0) || 1'b1;
  assign blink_on = STEADY_PHASE;
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      col_q     <= '0;
      hf_q      <= '0;
      row_q     <= '0;
      vf_q      <= '0;
      top_s_q   <= '0;
      cur_x_s_q <= '0;
      cur_y_s_q <= '0;
      en_s_q    <= 1'b0;
      h_font_q  <= '0;
      v_font_q  <= '0;
      c_valid_q <= 1'b0;
      cursor_q  <= 1'b0;
      hs1_q     <= 1'b1;
      hs2_q     <= 1'b1;
      vs1_q     <= 1'b1;
      vs2_q     <= 1'b1;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      col_q   <= col_d;
      hf_q    <= hf_d;
      row_q   <= row_d;
      vf_q    <= vf_d;
      if (fs) begin
        top_s_q   <= top_eff;
        cur_x_s_q <= cur_x_eff;
        cur_y_s_q <= cur_y_eff;
        en_s_q    <= en_eff;
      end
      h_font_q  <= hf_q;
      v_font_q  <= vf_q;
      c_valid_q <= in_area;
      cursor_q  <= cursor_hit;
      hs1_q     <= hs_raw;
      hs2_q     <= hs1_q;
      vs1_q     <= vs_raw;
      vs2_q     <= vs1_q;
    end
  end

  assign ram.ram_addr = rst ? '0 : addr;
  assign char         = ram.ram_rdata;
  assign h_font       = h_font_q;
  assign v_font       = v_font_q;
  assign c_valid      = c_valid_q;
  assign cursor       = cursor_q;
  assign hsync        = hs2_q;
  assign vsync        = vs2_q;
  assign frame_start  = fs & ~rst;

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Randomized bench for vga_text_ctrl on a shrunken raster, checked against a per-pixel arithmetic model.
module tb_vga_text_ctrl;

  localparam int unsigned HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int unsigned VV = 8,  VF = 1, VS = 1, VB = 1;
  localparam int unsigned CW = 3,  CH = 2, COLS = 5, ROWS = 4, BF = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FT = HT * VT;

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  hf;
    logic [3:0]  vf;
    logic        valid;
    logic        cur;
    logic        hs;
    logic        vs;
  } pix_t;

  localparam pix_t RST_PIX = '{addr: 12'd0, hf: 4'd0, vf: 4'd0, valid: 1'b0,
                               cur: 1'b0, hs: 1'b1, vs: 1'b1};

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic [4:0] top_row;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       cursor_en;
  logic [7:0] char;
  logic [3:0] h_font, v_font;
  logic       c_valid, cursor, hsync, vsync, frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned t;
  int unsigned m_top, m_cx, m_cy;
  logic        m_en;
  pix_t        prev1, prev2;

  vga_text_ctrl_if u_ram_if ();

  vga_text_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CELL_W(CW), .CELL_H(CH), .COLS(COLS), .ROWS(ROWS),
    .BLINK_FRAMES(BF)
  ) u_dut (
    .pclk(pclk), .rst(rst), .ram(u_ram_if.master),
    .top_row(top_row), .cur_x(cur_x), .cur_y(cur_y), .cursor_en(cursor_en),
    .char(char), .h_font(h_font), .v_font(v_font), .c_valid(c_valid),
    .cursor(cursor), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  function automatic logic [7:0] ram_word(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], 4'h5};
  endfunction

  always @(posedge pclk) u_ram_if.ram_rdata <= ram_word(u_ram_if.ram_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Expected values for raster position tt (cycles since reset release), straight from the rules.
  function automatic pix_t model_pix(input int unsigned tt);
    pix_t r;
    int unsigned p, h, v, col, row, frame;
    logic blink;
    p = tt % FT;
    h = p % HT;
    v = p / HT;
    frame = tt / FT;
    col = h / CW;
    row = v / CH;
    r.valid = (h < COLS * CW) && (v < ROWS * CH);
    r.addr  = r.valid ? 12'(((row + m_top) % ROWS) * COLS + col) : 12'd0;
    r.hf    = 4'(h % CW);
    r.vf    = 4'(v % CH);
`ifdef VGA_CURSOR_BLINK_EN
    blink = ((frame / BF) % 2) == 0;
`else
    blink = 1'b1;
`endif
    r.cur = r.valid && m_en && (col == m_cx) && (row == m_cy) && blink;
    r.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    r.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    return r;
  endfunction

  task automatic randomize_cfg();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: top_row = 5'($urandom_range(0, ROWS - 1));
      6, 7, 8:          top_row = 5'($urandom_range(ROWS, 7));
      default:          top_row = 5'd31;
    endcase
    cur_x     = 7'($urandom_range(0, COLS + 1));
    cur_y     = 5'($urandom_range(0, ROWS + 1));
    cursor_en = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_now();
    pix_t e;
    int unsigned p;
    p = t % FT;
    if (p == 0) begin
      m_top = (32'(top_row) >= ROWS) ? 0 : 32'(top_row);
      m_cx  = 32'(cur_x);
      m_cy  = 32'(cur_y);
      m_en  = cursor_en;
    end
    e = model_pix(t);
    check_eq("ram_addr",    32'(u_ram_if.ram_addr), 32'(e.addr));
    check_eq("frame_start", 32'(frame_start),       32'(p == 0));
    check_eq("h_font",      32'(h_font),            32'(prev1.hf));
    check_eq("v_font",      32'(v_font),            32'(prev1.vf));
    check_eq("c_valid",     32'(c_valid),           32'(prev1.valid));
    check_eq("cursor",      32'(cursor),            32'(prev1.cur));
    check_eq("char",        32'(char),              32'(ram_word(prev1.addr)));
    check_eq("hsync",       32'(hsync),             32'(prev2.hs));
    check_eq("vsync",       32'(vsync),             32'(prev2.vs));
    prev2 = prev1;
    prev1 = e;
    t++;
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check_now();
      @(posedge pclk);
      #1;
      if ($urandom_range(0, 99) < 2) randomize_cfg();
      #1;
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge pclk);
      #2;
      check_eq("rst_hsync",   32'(hsync),             32'd1);
      check_eq("rst_vsync",   32'(vsync),             32'd1);
      check_eq("rst_c_valid", 32'(c_valid),           32'd0);
      check_eq("rst_cursor",  32'(cursor),            32'd0);
      check_eq("rst_addr",    32'(u_ram_if.ram_addr), 32'd0);
      check_eq("rst_fstart",  32'(frame_start),       32'd0);
      check_eq("rst_char",    32'(char),              32'(ram_word(12'd0)));
    end
    rst = 1'b0;
    #1;
    prev1 = RST_PIX;
    prev2 = RST_PIX;
    t = 0;
  endtask

  initial begin
    top_row   = 5'(ROWS - 1);
    cur_x     = 7'd2;
    cur_y     = 5'd1;
    cursor_en = 1'b1;
    t = 0;
    do_reset(3);
    run_cycles(FT);
    top_row = 5'd31;
    cursor_en = 1'b1;
    run_cycles(14 * FT + 97);
    do_reset(2);
    run_cycles(8 * FT);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
